// File: rtl/subn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : subn_pkg
//  Description : Shared types and constants for the bit-serial subtractor.
//                Holds the controller state encoding and the default width.
//  Revision    : 1.0 - initial release
// ============================================================================
package subn_pkg;

  // Default operand/result width in bits.
  localparam int SUBN_DEFAULT_WIDTH = 8;

  // Controller states: wait for a request, shift one bit per cycle, present.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : subn_pkg
`default_nettype wire

// File: rtl/subn_serial_fsub_cell.sv
`default_nettype none
// ============================================================================
//  Module      : fsub_cell
//  Description : One-bit full subtractor, purely combinational.
//                d = a - b - bin (mod 2), bout = borrow out of this bit.
//  Ports       : a    in  minuend bit
//                b    in  subtrahend bit
//                bin  in  borrow in
//                d    out difference bit
//                bout out borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : fsub_cell
`default_nettype wire

// File: rtl/subn_serial.sv
`default_nettype none
// ============================================================================
//  Module      : subn_serial
//  Description : Bit-serial subtractor D = X - Y - borrowin (mod 2^WIDTH).
//                One bit per cycle, LSB first; WIDTH+2 cycles per result
//                (IDLE, WIDTH x RUN, DONE).
//  Ports       : clk        in  clock, rising edge
//                rst_n      in  asynchronous active-low reset
//                start      in  request, sampled only while ready=1
//                borrowin   in  borrow into bit 0
//                X, Y       in  minuend / subtrahend, captured on accept
//                ready      out high only in IDLE
//                done       out one-cycle pulse with a fresh result
//                D          out difference, held between results
//                borrowout  out borrow out of bit WIDTH-1
//                ovf        out signed overflow flag
//  Config      : SUBN_SERIAL_OVF_EN - when defined, ovf is computed and
//                registered with D; otherwise ovf is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module subn_serial
  import subn_pkg::*;
#(
  parameter int WIDTH = SUBN_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             borrowin,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrowout,
  output logic             ovf
);

  // Counter must also hold WIDTH, the value it reaches on leaving RUN.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_sh_q, x_sh_d;
  logic [WIDTH-1:0]   y_sh_q, y_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               b_q, b_d;
  logic               bout_q, bout_d;
  logic               cell_d, cell_bout;

`ifdef SUBN_SERIAL_OVF_EN
  // Operand sign bits are shifted out of the operand registers, so keep them.
  logic               x_msb_q, x_msb_d;
  logic               y_msb_q, y_msb_d;
  logic               ovf_q, ovf_d;
`endif

  fsub_cell u_cell (
    .a    (x_sh_q[0]),
    .b    (y_sh_q[0]),
    .bin  (b_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    res_d   = res_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    bout_d  = bout_q;
`ifdef SUBN_SERIAL_OVF_EN
    x_msb_d = x_msb_q;
    y_msb_d = y_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_sh_d  = X;
          y_sh_d  = Y;
          b_d     = borrowin;
          cnt_d   = '0;
`ifdef SUBN_SERIAL_OVF_EN
          x_msb_d = X[WIDTH-1];
          y_msb_d = Y[WIDTH-1];
`endif
        end
      end
      RUN: begin
        x_sh_d = {1'b0, x_sh_q[WIDTH-1:1]};
        y_sh_d = {1'b0, y_sh_q[WIDTH-1:1]};
        b_d    = cell_bout;
        // Entering at the MSB end means bit 0 lands in place after WIDTH shifts.
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          // Publish the completed result (including this last bit) in one go.
          dout_d  = res_d;
          bout_d  = cell_bout;
`ifdef SUBN_SERIAL_OVF_EN
          ovf_d   = (x_msb_q != y_msb_q) & (cell_d != x_msb_q);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_sh_q  <= '0;
      y_sh_q  <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUBN_SERIAL_OVF_EN
      x_msb_q <= 1'b0;
      y_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      bout_q  <= bout_d;
`ifdef SUBN_SERIAL_OVF_EN
      x_msb_q <= x_msb_d;
      y_msb_q <= y_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign D         = dout_q;
  assign borrowout = bout_q;

`ifdef SUBN_SERIAL_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule : subn_serial
`default_nettype wire
